// File: rtl/next_sram_ctrl.sv
// next_sram_ctrl: clear sequencer and write/read arbiter for the 16 x 64b "next" SRAM (4b lanes).
// Define NEXT_SRAM_CTRL_CONFLICT_CNT_EN to add the saturating same-word conflict counter output.

module next_sram_ctrl #(
   parameter int            ADDR_SPACE = 4,
   parameter int            Q          = 16,
   parameter int            BW         = 4,
   parameter logic [BW-1:0] CLEAR_VAL  = 4'hF
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            clr_start,
   output logic                            busy,
   output logic                            clr_done,
   input  logic                            wr_valid,
   output logic                            wr_ready,
   input  logic [ADDR_SPACE+$clog2(Q)-1:0] wr_idx,
   input  logic [BW-1:0]                   wr_data,
   input  logic                            rd_valid,
   output logic                            rd_ready,
   input  logic [ADDR_SPACE+$clog2(Q)-1:0] rd_idx,
   output logic                            rd_rsp_valid,
   output logic [BW-1:0]                   rd_rsp_data,
   output logic                            sram_wsb,
   output logic [BW*Q-1:0]                 sram_wdata,
   output logic [Q-1:0]                    sram_bytemask,
   output logic [ADDR_SPACE-1:0]           sram_waddr,
   output logic [ADDR_SPACE-1:0]           sram_raddr,
   input  logic [BW*Q-1:0]                 sram_rdata
`ifdef NEXT_SRAM_CTRL_CONFLICT_CNT_EN
   ,
   output logic [15:0]                     conflict_cnt
`endif
);

   localparam int LW = $clog2(Q);
   localparam int IW = ADDR_SPACE + LW;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [ADDR_SPACE-1:0] r_clr_cnt;
   logic                  r_clr_done;
   logic                  r_rr;
   logic [ADDR_SPACE-1:0] r_raddr;
   logic                  r_rd_v1;
   logic [LW-1:0]         r_rd_lane1;
   logic                  r_rsp_valid;
   logic [BW-1:0]         r_rsp_data;

   logic [ADDR_SPACE-1:0] w_wr_word;
   logic [ADDR_SPACE-1:0] w_rd_word;
   logic [LW-1:0]         w_wr_lane;
   logic [LW-1:0]         w_rd_lane;
   logic                  w_same_word;
   logic                  w_conflict;
   logic                  w_clr_enter;
   logic                  w_wr_gnt;
   logic                  w_rd_gnt;
   logic [BW-1:0]         w_rsp_lane;

   // Handshake: a request is accepted in the cycle where valid and ready are both high;
   // ready is a pure function of state and this cycle's requests, valid never waits on ready.
   assign w_wr_word   = wr_idx[IW-1:LW];
   assign w_wr_lane   = wr_idx[LW-1:0];
   assign w_rd_word   = rd_idx[IW-1:LW];
   assign w_rd_lane   = rd_idx[LW-1:0];
   assign w_same_word = (w_wr_word == w_rd_word);
   assign w_conflict  = (r_state == ST_RUN) && wr_valid && rd_valid && w_same_word;
   assign w_clr_enter = (r_state == ST_RUN) && clr_start;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_CLEAR;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_CLEAR: if (r_clr_cnt == '1) w_state_nxt = ST_RUN;
         ST_RUN:   if (clr_start)       w_state_nxt = ST_CLEAR;
      endcase
   end

   always_comb begin
      w_wr_gnt      = 1'b0;
      w_rd_gnt      = 1'b0;
      busy          = 1'b0;
      sram_wsb      = 1'b1;
      sram_waddr    = '0;
      sram_wdata    = '0;
      sram_bytemask = '0;
      case (r_state)
         ST_CLEAR: begin
            busy = 1'b1;
            // Held in reset the state already reads CLEAR, so the write strobe is gated off.
            if (rst_n) begin
               sram_wsb   = 1'b0;
               sram_waddr = r_clr_cnt;
               sram_wdata = {Q{CLEAR_VAL}};
            end
         end
         ST_RUN: begin
            w_wr_gnt = wr_valid && (!w_conflict || !r_rr);
            w_rd_gnt = rd_valid && (!w_conflict || r_rr);
            if (w_wr_gnt) begin
               sram_wsb      = 1'b0;
               sram_waddr    = w_wr_word;
               sram_wdata    = {Q{wr_data}};
               sram_bytemask = ~(Q'(1) << w_wr_lane);
            end
         end
      endcase
      sram_raddr = w_rd_gnt ? w_rd_word : r_raddr;
   end

   assign wr_ready     = w_wr_gnt;
   assign rd_ready     = w_rd_gnt;
   assign clr_done     = r_clr_done;
   assign rd_rsp_valid = r_rsp_valid;
   assign rd_rsp_data  = r_rsp_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_clr_cnt  <= '0;
         r_clr_done <= 1'b0;
         r_rr       <= 1'b0;
         r_raddr    <= '0;
      end else begin
         r_clr_done <= (r_state == ST_CLEAR) && (r_clr_cnt == '1);
         if (r_state == ST_CLEAR) begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
         end else if (w_clr_enter) begin
            r_clr_cnt <= '0;
         end
         if (w_conflict) begin
            r_rr <= ~r_rr;
         end
         if (w_rd_gnt) begin
            r_raddr <= w_rd_word;
         end
      end
   end

   always_comb begin
      w_rsp_lane = '0;
      for (int i = 0; i < Q; i++) begin
         if (r_rd_lane1 == LW'(i)) w_rsp_lane = sram_rdata[i*BW +: BW];
      end
   end

   // Two-stage read: lane captured with the grant, SRAM data lane-selected one cycle later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_v1     <= 1'b0;
         r_rd_lane1  <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
      end else begin
         r_rd_v1     <= w_rd_gnt;
         r_rsp_valid <= r_rd_v1;
         if (w_rd_gnt) begin
            r_rd_lane1 <= w_rd_lane;
         end
         if (r_rd_v1) begin
            r_rsp_data <= w_rsp_lane;
         end
      end
   end

`ifdef NEXT_SRAM_CTRL_CONFLICT_CNT_EN
   logic [15:0] r_conflict_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_conflict_cnt <= '0;
      end else if (w_clr_enter) begin
         r_conflict_cnt <= '0;
      end else if (w_conflict && (r_conflict_cnt != 16'hFFFF)) begin
         r_conflict_cnt <= r_conflict_cnt + 16'd1;
      end
   end

   assign conflict_cnt = r_conflict_cnt;
`else
   // Conflict counter not built: arbitration is unchanged.
`endif

   a_no_grant_in_clear : assert property (@(posedge clk) disable iff (!rst_n)
      (r_state == ST_CLEAR) |-> (!wr_ready && !rd_ready));
   a_done_one_cycle : assert property (@(posedge clk) disable iff (!rst_n)
      clr_done |=> !clr_done);
   a_run_mask_single_lane : assert property (@(posedge clk) disable iff (!rst_n)
      ((r_state == ST_RUN) && !sram_wsb) |-> $onehot(~sram_bytemask));

endmodule

// File: tb/tb_next_sram_ctrl.sv
// Directed bench for next_sram_ctrl: behavioural 16x64b SRAM, vector table for RUN arbitration,
// hand-written sequences for clear, read latency, conflicts, clear/read overlap and async reset.

module tb_next_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr_start;
  logic        busy;
  logic        clr_done;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  wr_idx;
  logic [3:0]  wr_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [7:0]  rd_idx;
  logic        rd_rsp_valid;
  logic [3:0]  rd_rsp_data;
  logic        sram_wsb;
  logic [63:0] sram_wdata;
  logic [15:0] sram_bytemask;
  logic [3:0]  sram_waddr;
  logic [3:0]  sram_raddr;
  logic [63:0] sram_rdata;
`ifdef NEXT_SRAM_CTRL_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  next_sram_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clr_start     (clr_start),
    .busy          (busy),
    .clr_done      (clr_done),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_idx        (wr_idx),
    .wr_data       (wr_data),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .rd_idx        (rd_idx),
    .rd_rsp_valid  (rd_rsp_valid),
    .rd_rsp_data   (rd_rsp_data),
    .sram_wsb      (sram_wsb),
    .sram_wdata    (sram_wdata),
    .sram_bytemask (sram_bytemask),
    .sram_waddr    (sram_waddr),
    .sram_raddr    (sram_raddr),
    .sram_rdata    (sram_rdata)
`ifdef NEXT_SRAM_CTRL_CONFLICT_CNT_EN
    ,
    .conflict_cnt  (conflict_cnt)
`endif
  );

  // SRAM model: active-low write, mask bit 1 keeps the old lane, registered read (old data on collision).
  logic [63:0] mem [16];
  logic [63:0] mem_merge;

  always_comb begin
    mem_merge = mem[sram_waddr];
    for (int l = 0; l < 16; l++) begin
      if (!sram_bytemask[l]) mem_merge[l*4 +: 4] = sram_wdata[l*4 +: 4];
    end
  end

  always @(posedge clk) begin
    sram_rdata <= mem[sram_raddr];
    if (!sram_wsb) mem[sram_waddr] <= mem_merge;
  end

  typedef struct {
    logic        wv;
    logic [7:0]  widx;
    logic [3:0]  wd;
    logic        rv;
    logic [7:0]  ridx;
    logic        e_wr;
    logic        e_rd;
    logic        e_wsb;
    logic [3:0]  e_waddr;
    logic [15:0] e_mask;
    logic [63:0] e_wdata;
    logic [3:0]  e_raddr;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    wr_valid  = 1'b0;
    rd_valid  = 1'b0;
    clr_start = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_wsb"},      sram_wsb,     1'b1);
    check({tag, "_wr_ready"}, wr_ready,     1'b0);
    check({tag, "_rd_ready"}, rd_ready,     1'b0);
    check({tag, "_rsp_vld"},  rd_rsp_valid, 1'b0);
    check({tag, "_rsp_data"}, rd_rsp_data,  4'h0);
    check({tag, "_clr_done"}, clr_done,     1'b0);
    check({tag, "_busy"},     busy,         1'b1);
`ifdef NEXT_SRAM_CTRL_CONFLICT_CNT_EN
    check({tag, "_cnt"},      conflict_cnt, 16'h0);
`endif
  endtask

  // Called in clear cycle 0; requests and clr_start are held high to show they are ignored.
  task automatic clear_seq(input string tag);
    for (int k = 0; k < 16; k++) begin
      wr_valid  = 1'b1;
      wr_idx    = 8'h25;
      wr_data   = 4'h0;
      rd_valid  = 1'b1;
      rd_idx    = 8'h25;
      clr_start = 1'b1;
      #1;
      check({tag, "_busy"},     busy,          1'b1);
      check({tag, "_wsb"},      sram_wsb,      1'b0);
      check({tag, "_waddr"},    sram_waddr,    k[3:0]);
      check({tag, "_mask"},     sram_bytemask, 16'h0000);
      check({tag, "_wdata"},    sram_wdata,    64'hFFFF_FFFF_FFFF_FFFF);
      check({tag, "_wr_ready"}, wr_ready,      1'b0);
      check({tag, "_rd_ready"}, rd_ready,      1'b0);
      check({tag, "_done_lo"},  clr_done,      1'b0);
      if (k == 15) idle();
      step();
    end
    #1;
    check({tag, "_done_hi"}, clr_done, 1'b1);
    check({tag, "_busy_lo"}, busy,     1'b0);
    step();
    #1;
    check({tag, "_done_pulse"}, clr_done, 1'b0);
  endtask

  // Grants a read in the current cycle and checks the response two cycles later.
  task automatic do_read(input logic [7:0] idx, input logic [3:0] exp, input string tag);
    wr_valid = 1'b0;
    rd_valid = 1'b1;
    rd_idx   = idx;
    #1;
    check({tag, "_rd_ready"}, rd_ready,   1'b1);
    check({tag, "_raddr"},    sram_raddr, idx[7:4]);
    step();
    rd_valid = 1'b0;
    #1;
    check({tag, "_rsp_early"}, rd_rsp_valid, 1'b0);
    step();
    #1;
    check({tag, "_rsp_vld"},  rd_rsp_valid, 1'b1);
    check({tag, "_rsp_data"}, rd_rsp_data,  exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    //            wv    widx   wd    rv    ridx   wr    rd    wsb   waddr  mask      wdata                   raddr
    vecs[0] = '{1'b0, 8'h00, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'h0, 16'h0000, 64'h0,                  4'h4};
    vecs[1] = '{1'b1, 8'hA3, 4'h5, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'hA, 16'hFFF7, 64'h5555_5555_5555_5555, 4'h4};
    vecs[2] = '{1'b0, 8'h00, 4'h0, 1'b1, 8'h9C, 1'b0, 1'b1, 1'b1, 4'h0, 16'h0000, 64'h0,                  4'h9};
    vecs[3] = '{1'b1, 8'h0F, 4'hC, 1'b1, 8'h7E, 1'b1, 1'b1, 1'b0, 4'h0, 16'h7FFF, 64'hCCCC_CCCC_CCCC_CCCC, 4'h7};
    vecs[4] = '{1'b1, 8'h62, 4'hA, 1'b1, 8'h6D, 1'b1, 1'b0, 1'b0, 4'h6, 16'hFFFB, 64'hAAAA_AAAA_AAAA_AAAA, 4'h7};
    vecs[5] = '{1'b1, 8'h62, 4'hA, 1'b1, 8'h6D, 1'b0, 1'b1, 1'b1, 4'h0, 16'h0000, 64'h0,                  4'h6};
    vecs[6] = '{1'b1, 8'hF8, 4'h2, 1'b1, 8'hF0, 1'b1, 1'b0, 1'b0, 4'hF, 16'hFEFF, 64'h2222_2222_2222_2222, 4'h6};
    vecs[7] = '{1'b1, 8'h11, 4'h6, 1'b1, 8'h21, 1'b1, 1'b1, 1'b0, 4'h1, 16'hFFFD, 64'h6666_6666_6666_6666, 4'h2};
    vecs[8] = '{1'b1, 8'h33, 4'h4, 1'b1, 8'h3F, 1'b0, 1'b1, 1'b1, 4'h0, 16'h0000, 64'h0,                  4'h3};
    vecs[9] = '{1'b0, 8'h00, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'h0, 16'h0000, 64'h0,                  4'h3};

    rst_n = 1'b1;
    idle();
    wr_idx  = 8'h00;
    wr_data = 4'h0;
    rd_idx  = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("t1_reset");

    // 1: clear after reset release, then a read of cleared data
    @(negedge clk);
    rst_n = 1'b1;
    clear_seq("t1_clr");
    do_read(8'h37, 4'hF, "t1_rd37");

    // 2: single write, then reads of the written and a neighbouring lane
    wr_valid = 1'b1;
    wr_idx   = 8'h25;
    wr_data  = 4'h3;
    #1;
    check("t2_wr_ready", wr_ready,      1'b1);
    check("t2_wsb",      sram_wsb,      1'b0);
    check("t2_waddr",    sram_waddr,    4'h2);
    check("t2_mask",     sram_bytemask, 16'hFFDF);
    check("t2_wdata",    sram_wdata,    64'h3333_3333_3333_3333);
    step();
    do_read(8'h25, 4'h3, "t2_rd25");
    do_read(8'h24, 4'hF, "t2_rd24");

    // 3: same-word conflicts alternate between write and read
    wr_valid = 1'b1;
    wr_idx   = 8'h15;
    wr_data  = 4'h7;
    rd_valid = 1'b1;
    rd_idx   = 8'h15;
    #1;
    check("t3_c1_wr_ready", wr_ready,      1'b1);
    check("t3_c1_rd_ready", rd_ready,      1'b0);
    check("t3_c1_waddr",    sram_waddr,    4'h1);
    check("t3_c1_mask",     sram_bytemask, 16'hFFDF);
    check("t3_c1_wdata",    sram_wdata,    64'h7777_7777_7777_7777);
    step();
    do_read(8'h15, 4'h7, "t3_rd_after_wr");
    wr_valid = 1'b1;
    wr_idx   = 8'h15;
    wr_data  = 4'h9;
    rd_valid = 1'b1;
    rd_idx   = 8'h15;
    #1;
    check("t3_c2_rd_ready", rd_ready, 1'b1);
    check("t3_c2_wr_ready", wr_ready, 1'b0);
    check("t3_c2_wsb",      sram_wsb, 1'b1);
    step();
    rd_valid = 1'b0;
    #1;
    check("t3_c2_wr_late",  wr_ready,     1'b1);
    check("t3_c2_wdata",    sram_wdata,   64'h9999_9999_9999_9999);
    check("t3_c2_rsp_early", rd_rsp_valid, 1'b0);
    step();
    wr_valid = 1'b0;
    #1;
    check("t3_c2_rsp_vld",  rd_rsp_valid, 1'b1);
    check("t3_c2_rsp_data", rd_rsp_data,  4'h7);
    step();
    do_read(8'h15, 4'h9, "t3_rd_new");

    // 4: different words granted together; back-to-back pipelined reads
    wr_valid = 1'b1;
    wr_idx   = 8'h40;
    wr_data  = 4'h1;
    rd_valid = 1'b1;
    rd_idx   = 8'h2A;
    #1;
    check("t4_wr_ready", wr_ready,      1'b1);
    check("t4_rd_ready", rd_ready,      1'b1);
    check("t4_waddr",    sram_waddr,    4'h4);
    check("t4_mask",     sram_bytemask, 16'hFFFE);
    check("t4_wdata",    sram_wdata,    64'h1111_1111_1111_1111);
    check("t4_raddr",    sram_raddr,    4'h2);
    step();
    idle();
    #1;
    check("t4_rsp_early", rd_rsp_valid, 1'b0);
    step();
    #1;
    check("t4_rsp_vld",  rd_rsp_valid, 1'b1);
    check("t4_rsp_data", rd_rsp_data,  4'hF);
    step();
    rd_valid = 1'b1;
    rd_idx   = 8'h40;
    #1;
    check("t4_b0_rd_ready", rd_ready, 1'b1);
    step();
    rd_idx = 8'h41;
    #1;
    check("t4_b1_rd_ready", rd_ready,     1'b1);
    check("t4_b1_raddr",    sram_raddr,   4'h4);
    check("t4_b1_rsp_vld",  rd_rsp_valid, 1'b0);
    step();
    rd_valid = 1'b0;
    #1;
    check("t4_b2_rsp_vld",  rd_rsp_valid, 1'b1);
    check("t4_b2_rsp_data", rd_rsp_data,  4'h1);
    step();
    #1;
    check("t4_b3_rsp_vld",  rd_rsp_valid, 1'b1);
    check("t4_b3_rsp_data", rd_rsp_data,  4'hF);
    step();
    #1;
    check("t4_b4_rsp_vld",  rd_rsp_valid, 1'b0);

    // RUN arbitration table, round-robin starts at 0 here
    for (int i = 0; i < 10; i++) begin
      wr_valid = vecs[i].wv;
      wr_idx   = vecs[i].widx;
      wr_data  = vecs[i].wd;
      rd_valid = vecs[i].rv;
      rd_idx   = vecs[i].ridx;
      #1;
      check($sformatf("tab%0d_wr_ready", i), wr_ready,      vecs[i].e_wr);
      check($sformatf("tab%0d_rd_ready", i), rd_ready,      vecs[i].e_rd);
      check($sformatf("tab%0d_wsb", i),      sram_wsb,      vecs[i].e_wsb);
      check($sformatf("tab%0d_waddr", i),    sram_waddr,    vecs[i].e_waddr);
      check($sformatf("tab%0d_mask", i),     sram_bytemask, vecs[i].e_mask);
      check($sformatf("tab%0d_wdata", i),    sram_wdata,    vecs[i].e_wdata);
      check($sformatf("tab%0d_raddr", i),    sram_raddr,    vecs[i].e_raddr);
      step();
    end
    idle();
    do_read(8'h62, 4'hA, "tab_rd62");
`ifdef NEXT_SRAM_CTRL_CONFLICT_CNT_EN
    check("cnt_before_clear", conflict_cnt, 16'd6);
`endif

    // 5: clr_start right after a read grant; the read still returns pre-clear data
    step();
    rd_valid = 1'b1;
    rd_idx   = 8'h25;
    #1;
    check("t5_rd_ready", rd_ready, 1'b1);
    step();
    rd_valid  = 1'b0;
    clr_start = 1'b1;
    #1;
    check("t5_rsp_early", rd_rsp_valid, 1'b0);
    check("t5_busy_lo",   busy,         1'b0);
    step();
    clr_start = 1'b0;
    #1;
    check("t5_rsp_vld",  rd_rsp_valid, 1'b1);
    check("t5_rsp_data", rd_rsp_data,  4'h3);
`ifdef NEXT_SRAM_CTRL_CONFLICT_CNT_EN
    check("t5_cnt_cleared", conflict_cnt, 16'd0);
`endif
    clear_seq("t5_clr");
    do_read(8'h25, 4'hF, "t5_rd25");

    // 6: async reset in the middle of a clear restarts it from word 0
    rd_valid  = 1'b1;
    rd_idx    = 8'h25;
    clr_start = 1'b1;
    #1;
    check("t6_rd_with_clr", rd_ready, 1'b1);
    step();
    idle();
    #1;
    check("t6_busy",       busy,         1'b1);
    check("t6_waddr0",     sram_waddr,   4'h0);
    check("t6_rsp_early",  rd_rsp_valid, 1'b0);
    step();
    #1;
    check("t6_rsp_vld",    rd_rsp_valid, 1'b1);
    check("t6_rsp_data",   rd_rsp_data,  4'hF);
    check("t6_waddr1",     sram_waddr,   4'h1);
    repeat (6) step();
    #1;
    check("t6_waddr7",     sram_waddr,   4'h7);
    rst_n = 1'b0;
    #1;
    check_reset_vals("t6_reset");
    step();
    #1;
    check("t6_reset_hold_wsb", sram_wsb, 1'b1);
    rst_n = 1'b1;
    clear_seq("t6_clr");
`ifdef NEXT_SRAM_CTRL_CONFLICT_CNT_EN
    check("t6_cnt", conflict_cnt, 16'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/next_sram_ctrl.md
Name: next_sram_ctrl

Overview:
- Controller and arbiter for the 16-word x 64-bit "next" SRAM: 16 lanes of 4b per word, write port active-low, active-high bytemask meaning "keep old lane", 1-cycle registered read.
- Shares the SRAM between one element-write requester and one element-read requester, both addressing single 4b elements by flat index.
- Translates each index to word address and lane, and generates replicated wdata and the lane bytemask.
- Runs an automatic clear sequence after reset and on demand.

Parameters:
- ADDR_SPACE, 4, SRAM word-address width (2^ADDR_SPACE words).
- Q, 16, lanes per word; lane-select width LW = log2(Q) = 4.
- BW, 4, bits per lane/element.
- CLEAR_VAL, 4'hF, element value written by clear sequence.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- clr_start  in  1  pulse: start clear sequence.
- busy  out  1  high while clearing.
- clr_done  out  1  one-cycle pulse when clear completes.
- wr_valid  in  1  write request.
- wr_ready  out  1  write grant.
- wr_idx  in  ADDR_SPACE+LW  element index: [MSBs]=word, [LW-1:0]=lane.
- wr_data  in  BW  element value.
- rd_valid  in  1  read request.
- rd_ready  out  1  read grant.
- rd_idx  in  ADDR_SPACE+LW  element index.
- rd_rsp_valid  out  1  read response strobe.
- rd_rsp_data  out  BW  read response value.
- sram_wsb  out  1  SRAM write enable, active low.
- sram_wdata  out  BW*Q  SRAM write data.
- sram_bytemask  out  Q  SRAM lane mask; 1 = keep old lane.
- sram_waddr  out  ADDR_SPACE  SRAM write address.
- sram_raddr  out  ADDR_SPACE  SRAM read address.
- sram_rdata  in  BW*Q  SRAM read data, valid the cycle after raddr is sampled.

Behaviour:
- Reset: state=CLEAR, clr_cnt=0, rr=0.
- Reset output values: sram_wsb=1, wr_ready=0, rd_ready=0, rd_rsp_valid=0, rd_rsp_data=0, clr_done=0, busy=1. Clear starts automatically on reset release.
- FSM states are CLEAR and RUN.
- CLEAR, each cycle:
  - sram_wsb=0, sram_waddr=clr_cnt, sram_bytemask=0, sram_wdata={Q{CLEAR_VAL}}, clr_cnt++.
  - After word 2^ADDR_SPACE-1: go to RUN, clr_done=1 for one cycle.
  - Takes exactly 2^ADDR_SPACE cycles. wr_ready=rd_ready=0 throughout. clr_start is ignored.
- RUN:
  - clr_start=1 → CLEAR next cycle, clr_cnt=0.
  - Grants are still evaluated in the cycle clr_start is seen.
- Grants in RUN (combinational; valid must not depend on ready):
  - Only one requester valid → it is granted.
  - Both valid, different word address → both granted in the same cycle.
  - Both valid, same word → rr=0 grants write, rr=1 grants read; rr then toggles. rr changes only on such conflicts.
- Write grant, same cycle:
  - sram_wsb=0, sram_waddr=wr_idx word, sram_wdata={Q{wr_data}}.
  - sram_bytemask = all ones except bit lane = 0. Memory updates at that edge.
  - No write granted → sram_wsb=1, other write outputs don't-care, driven 0.
- Read grant in cycle t:
  - sram_raddr = rd_idx word in t; the lane is registered.
  - In t+1, the selected lane of sram_rdata is registered into rd_rsp_data.
  - rd_rsp_valid=1 in t+2 for one cycle; latency 2, one read per cycle fully pipelined. No response backpressure.
  - sram_raddr holds its previous value when no read is granted.
- Ordering and clear interaction:
  - A write granted in cycle t is visible to a read granted in t+1 or later.
  - A same-cycle read of a different word is unaffected.
  - Reads already granted when CLEAR starts still complete with pre-clear data.
- Async reset mid-operation: in-flight responses are dropped and the clear restarts from word 0.

Optional Feature:
- Macro NEXT_SRAM_CTRL_CONFLICT_CNT_EN.
- When defined:
  - Adds output conflict_cnt [15:0], which increments each RUN cycle with a same-word conflict.
  - Saturates at 16'hFFFF.
  - Cleared by reset and when entering CLEAR.
- When undefined: no port and no logic. Functionally identical otherwise.

Test Plan:
1. Reset release: busy=1 for 16 cycles, sram_wsb low with waddr 0..15 and bytemask 0, clr_done pulse. Then read idx 8'h37 → rd_rsp_valid 2 cycles later, data 4'hF.
2. Write idx 8'h25 data 4'h3 → sram_waddr=2, bytemask=16'hFFDF, wdata=64'h3333_3333_3333_3333. Read 8'h25 next cycle → 4'h3; read 8'h24 → 4'hF.
3. Same-cycle write 8'h15=4'h7 and read 8'h15 with rr=0 → write granted, read stalled. Read granted next cycle → 4'h7. Next conflict (write 8'h15=4'h9, read 8'h15) → read granted first, returns 4'h7.
4. Same-cycle write 8'h40=4'h1 and read 8'h2A (different words) → both ready in the same cycle, read returns 4'hF. Back-to-back reads 8'h40, 8'h41 → responses 4'h1, 4'hF on consecutive cycles.
5. clr_start one cycle after a read grant of 8'h25 (holding 4'h3) → response 4'h3 still delivered, ready low for 16 cycles, clr_done pulse. Subsequent read 8'h25 → 4'hF.
6. Assert rst_n low at clear word 7 → outputs return to reset values. On release, clear restarts at waddr 0 and takes the full 16 cycles. With the macro defined, conflict_cnt reads 0.
